// File: rtl/pipelined_mux_tree_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_mux_pkg
// Shared definitions for the pipelined N:1 channel selector.
//   chan_count(levels) : number of channels served by a tree of the given depth
//   SEL_W              : select index width for the default two-level tree
//   sel_idx_t          : select index type for the default two-level tree
// ---------------------------------------------------------------------------
package pipelined_mux_pkg;

    localparam int DEF_LEVELS = 2;
    localparam int SEL_W      = 2 * DEF_LEVELS;

    typedef logic [SEL_W-1:0] sel_idx_t;

    // Channel count of a 4-ary tree: 4**levels.
    function automatic int chan_count(input int levels);
        return 32'sd1 << (32'sd2 * levels);
    endfunction

endpackage

// File: rtl/pipelined_mux_tree_mux4_reg_stage.sv
// ---------------------------------------------------------------------------
// mux4_reg_stage
// One 4:1 multiplexer followed by an output register.
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset, clears the output register
//   i_din    : four packed inputs, input j = i_din[j*WIDTH +: WIDTH]
//   i_sel    : 2-bit select
//   o_dout   : registered selected input
// ---------------------------------------------------------------------------
module mux4_reg_stage #(
    parameter int WIDTH = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [4*WIDTH-1:0] i_din,
    input  logic [1:0]         i_sel,
    output logic [WIDTH-1:0]   o_dout
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_dout;

    // Combinational 4:1 select.
    always_comb begin
        w_mux = '0;
        case (i_sel)
            2'd0:    w_mux = i_din[0*WIDTH +: WIDTH];
            2'd1:    w_mux = i_din[1*WIDTH +: WIDTH];
            2'd2:    w_mux = i_din[2*WIDTH +: WIDTH];
            2'd3:    w_mux = i_din[3*WIDTH +: WIDTH];
            default: w_mux = '0;
        endcase
    end

    // Output register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_mux;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/pipelined_mux_tree.sv
// ---------------------------------------------------------------------------
// pipelined_mux_tree
// Pipelined N:1 channel selector (N = 4**LEVELS), one register stage per
// tree level, with a valid flag and channel index travelling alongside the
// data. In scan mode an internal counter picks the channel, advancing once
// per accepted beat.
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset
//   i_din       : N packed channels, channel i = i_din[i*WIDTH +: WIDTH]
//   i_sel       : channel index used when i_scan_en = 0
//   i_in_valid  : input beat present this cycle
//   i_scan_en   : 1 = use the internal scan counter instead of i_sel
//   o_dout      : selected channel data (LEVELS cycles after the beat)
//   o_out_valid : o_dout / o_out_ch valid
//   o_out_ch    : index of the channel in o_dout
// ---------------------------------------------------------------------------
module pipelined_mux_tree
    import pipelined_mux_pkg::*;
#(
    parameter  int WIDTH  = 1,
    parameter  int LEVELS = 2,
    localparam int N      = chan_count(LEVELS),
    localparam int SELW   = 2 * LEVELS
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N*WIDTH-1:0] i_din,
    input  logic [SELW-1:0]    i_sel,
    input  logic               i_in_valid,
    input  logic               i_scan_en,
    output logic [WIDTH-1:0]   o_dout,
    output logic               o_out_valid,
    output logic [SELW-1:0]    o_out_ch
);

    logic [SELW-1:0] r_scan_cnt;
    logic [SELW-1:0] w_eff_sel;
    logic [SELW-1:0] r_sel_d [LEVELS];
    logic [LEVELS-1:0] r_vld_d;

    // The counter is held at 0 outside scan mode, so the first scan beat
    // always uses channel 0 even when scan_en rises together with in_valid.
    assign w_eff_sel = i_scan_en ? r_scan_cnt : i_sel;

    // Scan counter: advances on each accepted beat, wraps naturally at N.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
        end else if (!i_scan_en) begin
            r_scan_cnt <= '0;
        end else if (i_in_valid) begin
            r_scan_cnt <= r_scan_cnt + SELW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt;
        end
    end

    // Select/valid delay line, stage j aligned with tree level j's registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int j = 0; j < LEVELS; j++) begin
                r_sel_d[j] <= '0;
                r_vld_d[j] <= 1'b0;
            end
        end else begin
            r_sel_d[0] <= w_eff_sel;
            r_vld_d[0] <= i_in_valid;
            for (int j = 1; j < LEVELS; j++) begin
                r_sel_d[j] <= r_sel_d[j-1];
                r_vld_d[j] <= r_vld_d[j-1];
            end
        end
    end

    // Tree: level k has N/4**(k+1) registered 4:1 muxes. Level 0 uses the
    // live select; deeper levels use the copy delayed alongside their data.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int M = N >> (2 * (k + 1));

        logic [4*M*WIDTH-1:0] w_in;
        logic [M*WIDTH-1:0]   w_out;
        logic [1:0]           w_sel;

        if (k == 0) begin : g_src
            assign w_in  = i_din;
            assign w_sel = w_eff_sel[1:0];
        end else begin : g_src
            assign w_in  = g_lvl[k-1].w_out;
            assign w_sel = r_sel_d[k-1][2*k +: 2];
        end

        for (genvar m = 0; m < M; m++) begin : g_mux
            mux4_reg_stage #(
                .WIDTH (WIDTH)
            ) u_mux (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_din   (w_in[m*4*WIDTH +: 4*WIDTH]),
                .i_sel   (w_sel),
                .o_dout  (w_out[m*WIDTH +: WIDTH])
            );
        end
    end

    assign o_dout      = g_lvl[LEVELS-1].w_out;
    assign o_out_valid = r_vld_d[LEVELS-1];
    assign o_out_ch    = r_sel_d[LEVELS-1];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// ---------------------------------------------------------------------------
// tb_pipelined_mux_tree
// Scoreboard bench: u_dut_a (LEVELS=2, WIDTH=8) gets every scenario with
// expected beats queued on issue and popped when due; u_dut_b (LEVELS=3,
// WIDTH=4) checks the 64-channel latency and selection directly.
// ---------------------------------------------------------------------------
module tb_pipelined_mux_tree;

    localparam int LV  = 2;
    localparam int W   = 8;
    localparam int N   = 16;
    localparam int SW  = 4;
    localparam int LVB = 3;
    localparam int WB  = 4;
    localparam int NB  = 64;
    localparam int SWB = 6;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  din;
    logic [SW-1:0]   sel;
    logic            in_valid;
    logic            scan_en;
    logic [W-1:0]    dout;
    logic            out_valid;
    logic [SW-1:0]   out_ch;

    logic [NB*WB-1:0] din_b;
    logic [SWB-1:0]   sel_b;
    logic             in_valid_b;
    logic [WB-1:0]    dout_b;
    logic             out_valid_b;
    logic [SWB-1:0]   out_ch_b;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] ch;
        int            due;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] chan [N];
    logic [SW-1:0] m_cnt;
    logic [15:0]  pat;
    int           cyc;
    int           n_checks;
    int           n_errors;

    pipelined_mux_tree #(.WIDTH(W), .LEVELS(LV)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_din       (din),
        .i_sel       (sel),
        .i_in_valid  (in_valid),
        .i_scan_en   (scan_en),
        .o_dout      (dout),
        .o_out_valid (out_valid),
        .o_out_ch    (out_ch)
    );

    pipelined_mux_tree #(.WIDTH(WB), .LEVELS(LVB)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_din       (din_b),
        .i_sel       (sel_b),
        .i_in_valid  (in_valid_b),
        .i_scan_en   (1'b0),
        .o_dout      (dout_b),
        .o_out_valid (out_valid_b),
        .o_out_ch    (out_ch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_din();
        for (int i = 0; i < N; i++) begin
            din[i*W +: W] = chan[i];
        end
    endtask

    // One clock edge, then update the scan model and check DUT A.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n || !scan_en) begin
            m_cnt = '0;
        end else if (in_valid) begin
            m_cnt = m_cnt + 4'd1;
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check_val("out_valid", {31'd0, out_valid}, 32'd1);
            check_val("dout", {24'd0, dout}, {24'd0, sb[0].data});
            check_val("out_ch", {28'd0, out_ch}, {28'd0, sb[0].ch});
            void'(sb.pop_front());
        end else begin
            check_val("out_valid_idle", {31'd0, out_valid}, 32'd0);
        end
    endtask

    // Drive one cycle of DUT A stimulus and queue its expected result.
    task automatic beat(input logic v, input logic s, input logic [SW-1:0] sl);
        logic [SW-1:0] ch;
        in_valid = v;
        scan_en  = s;
        sel      = sl;
        if (v && rst_n) begin
            ch = s ? m_cnt : sl;
            sb.push_back('{data: chan[ch], ch: ch, due: cyc + LV});
        end
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        m_cnt      = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        scan_en    = 1'b0;
        sel        = '0;
        din        = '0;
        din_b      = '0;
        sel_b      = '0;
        in_valid_b = 1'b0;
        for (int i = 0; i < N; i++) chan[i] = '0;

        // Reset state
        tick();
        tick();
        check_val("rst_dout", {24'd0, dout}, 32'd0);
        check_val("rst_ch", {28'd0, out_ch}, 32'd0);
        check_val("rst_vld_b", {31'd0, out_valid_b}, 32'd0);
        check_val("rst_dout_b", {28'd0, dout_b}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Fixed select sweep over the 16'hA5C3 bit pattern
        pat = 16'hA5C3;
        for (int i = 0; i < N; i++) chan[i] = {7'd0, pat[i]};
        set_din();
        for (int i = 0; i < N; i++) beat(1'b1, 1'b0, SW'(i));
        repeat (3) beat(1'b0, 1'b0, '0);

        // Scan mode, 20 back-to-back beats, wraps 15 -> 0
        for (int i = 0; i < N; i++) chan[i] = 8'h10 + W'(i);
        set_din();
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b1, '0);
        repeat (3) beat(1'b0, 1'b0, '0);

        // Gapped scan, scan_en rising together with the first beat
        beat(1'b1, 1'b1, 4'd9);
        beat(1'b0, 1'b1, 4'd9);
        beat(1'b1, 1'b1, 4'd9);
        beat(1'b1, 1'b1, 4'd9);
        beat(1'b0, 1'b1, 4'd9);
        repeat (3) beat(1'b0, 1'b1, '0);

        // Reset with beats in flight
        repeat (3) beat(1'b1, 1'b1, '0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sb.delete();
        tick();
        check_val("mid_rst_dout", {24'd0, dout}, 32'd0);
        check_val("mid_rst_ch", {28'd0, out_ch}, 32'd0);
        rst_n = 1'b1;
        repeat (2) beat(1'b0, 1'b1, '0);
        beat(1'b1, 1'b1, '0);
        repeat (3) beat(1'b0, 1'b0, '0);

        // Select and data change every cycle while beats are in flight
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < N; c++) chan[c] = W'($urandom_range(255, 0));
            set_din();
            beat(($urandom_range(3, 0) != 0), 1'b0, SW'($urandom_range(15, 0)));
        end
        repeat (3) beat(1'b0, 1'b0, '0);

        // 64-channel tree: three-cycle latency, channel 45 then 46
        din_b[45*WB +: WB] = 4'h9;
        in_valid_b = 1'b1;
        sel_b      = 6'd45;
        beat(1'b0, 1'b0, '0);
        sel_b = 6'd46;
        beat(1'b0, 1'b0, '0);
        in_valid_b = 1'b0;
        sel_b      = 6'd0;
        check_val("b_vld_early", {31'd0, out_valid_b}, 32'd0);
        beat(1'b0, 1'b0, '0);
        check_val("b_vld45", {31'd0, out_valid_b}, 32'd1);
        check_val("b_dout45", {28'd0, dout_b}, 32'h9);
        check_val("b_ch45", {26'd0, out_ch_b}, 32'd45);
        beat(1'b0, 1'b0, '0);
        check_val("b_vld46", {31'd0, out_valid_b}, 32'd1);
        check_val("b_dout46", {28'd0, dout_b}, 32'h0);
        check_val("b_ch46", {26'd0, out_ch_b}, 32'd46);
        beat(1'b0, 1'b0, '0);
        check_val("b_vld_after", {31'd0, out_valid_b}, 32'd0);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_mux_tree.md
# pipelined_mux_tree

Parametrised, pipelined N:1 channel selector that generalises the team's 16:1 single-bit tree of 4:1 multiplexers. It supports a configurable channel width, a configurable tree depth (4^LEVELS channels), one register stage per tree level, and a valid flag carried alongside the data. An auto-scan mode steps through all channels in turn, one per valid input beat. It sits between the parallel sensor and switch inputs and any downstream serial consumer that needs one channel per cycle together with that channel's index.

## Interface
- WIDTH, default 1: bits per channel.
- LEVELS, default 2: tree depth; channel count N = 4**LEVELS (default 16).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- din  in  N*WIDTH  packed channels; channel i = din[i*WIDTH +: WIDTH].
- sel  in  2*LEVELS  channel index used when scan_en=0; sel[1:0] drives level 0 (leaf), sel[2k+1:2k] drives level k.
- in_valid  in  1  input beat present this cycle.
- scan_en  in  1  1 = use the internal scan counter instead of sel.
- dout  out  WIDTH  selected channel data.
- out_valid  out  1  dout/out_ch valid this cycle.
- out_ch  out  2*LEVELS  index of the channel in dout.

## Operation
- Effective select eff_sel = scan_en ? scan_cnt : sel, sampled in the cycle in_valid is high.
- Level 0: N/4 4:1 muxes choose with eff_sel[1:0], and the results are registered. Level k: N/4^(k+1) muxes operate on the level k-1 registers, choose with the delayed eff_sel[2k+1:2k], and the results are registered.
- eff_sel and in_valid travel down a matching delay line, one stage per level. Each level uses only the bits it needs; the full index comes out as out_ch.
- The pipeline has no stall or backpressure. Every stage advances every cycle, and invalid beats propagate with valid=0.
- scan_cnt is 2*LEVELS bits wide.
  - It is held at 0 while scan_en=0.
  - While scan_en=1 it increments by 1 on each cycle with in_valid=1.
  - It wraps from N-1 to 0.
- Changing scan_en or sel mid-stream affects only beats accepted after the change. Beats already in flight complete with their captured index.
- Data registers are don't-care while the valid bit in the same stage is 0. They may update freely, but dout must not be checked when out_valid=0.

## Timing
- Latency is exactly LEVELS cycles: a beat with in_valid=1 at edge t appears with out_valid=1 at edge t+LEVELS.
- Throughput is one beat per cycle, with back-to-back beats allowed.
- Reset (rst_n=0 at an edge):
  - out_valid, every internal valid stage, dout, out_ch, all data/select pipeline registers and scan_cnt go to 0.
  - Beats in flight are dropped and no stale out_valid appears afterwards.
  - The first beat accepted after reset is released at the edge where rst_n=1, and in scan mode it uses channel 0.
- Simultaneous in_valid=1 and scan_en 0→1 in the same cycle: that beat uses scan_cnt=0, and the counter becomes 1.
- Reset takes priority over in_valid and scan_en.

## Structure
- Package pipelined_mux_pkg contains:
  - the function chan_count(LEVELS) = 4**LEVELS;
  - the localparam SEL_W = 2*LEVELS helper;
  - a typedef for the select index.
- Sub-module mux4_reg_stage (parameter WIDTH): a single 4:1 mux with an output register and synchronous active-low reset. It is instantiated N/4 + N/16 + … + 1 times through a generate loop per level.
- Top level contents: the generate tree, the select/valid delay line and the scan counter.

## Test plan
- LEVELS=2, WIDTH=1: din=16'hA5C3, scan_en=0, sel 0..15 on consecutive cycles with in_valid=1 → starting 2 cycles later, dout is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, out_ch is 0..15 and out_valid stays 1 for 16 cycles.
- LEVELS=2, WIDTH=8: din channel i = 8'h10+i, scan_en=1, in_valid=1 for 20 cycles → dout 8'h10..8'h1F then 8'h10..8'h13, with out_ch wrapping 15→0.
- Gapped input: in_valid pattern 1,0,1,1,0 with scan_en=1 → out_valid pattern 1,0,1,1,0 delayed by 2 cycles, and out_ch is 0,–,1,2 (the counter does not advance on gaps).
- Reset mid-stream: 3 beats in flight, then rst_n=0 for 1 cycle → out_valid is 0 for the next 2 cycles, dout=0, and the next scan beat reports out_ch=0.
- LEVELS=3, WIDTH=4 (64 channels): sel=6'd45 with din channel 45 = 4'h9 and all others 0 → dout=4'h9 and out_ch=45 exactly 3 cycles later.
- sel changes on every cycle while beats are in flight → each output matches the sel captured with its own beat; there is no cross-beat mixing.
